// File: rtl/bram_cfg_dp.sv
// Simple dual-port block RAM with configurable port widths and byte-lane write masking.
// Reads are write-first, with an optional output register and a zeroing sweep after reset or on request.
module bram_cfg_dp #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [1:0]        cfg_wr_width,
    input  logic [1:0]        cfg_rd_width,
    input  logic              cfg_always_we,
    input  logic              cfg_out_reg,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int N_LANE  = DATA_W / 8;
    localparam int HALF_W  = DATA_W / 2;
    localparam int QUART_W = DATA_W / 4;
    localparam int LANES_H = N_LANE / 2;
    localparam int LANES_Q = N_LANE / 4;

    typedef enum logic [1:0] {
        W_FULL  = 2'd0,
        W_HALF  = 2'd1,
        W_QUART = 2'd2,
        W_RSVD  = 2'd3
    } width_t;

    // ST_LAST is the final sweep cycle (address DEPTH-1); it exits to READY.
    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LAST  = 2'd2
    } state_t;

    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_ptr;

    logic              wr_acc, rd_acc;
    logic [N_LANE-1:0] wr_be;
    logic [DATA_W-1:0] wr_word;

    logic [N_LANE-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_word, rd_slice;
    logic              v1, v2;
    logic [DATA_W-1:0] d1, d2;

    // ------------------------------------------------------------------
    // Sweep state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RESET;
            clr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (busy) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 2)) state_nx = ST_LAST;
            end
            ST_LAST: begin
                busy     = 1'b1;
                state_nx = ST_READY;
            end
            ST_READY: begin
                if (clr_req) state_nx = ST_CLEAR;
            end
            default: state_nx = ST_RESET;
        endcase
    end

    assign wr_acc = !busy && (wr_en || cfg_always_we);
    assign rd_acc = !busy && rd_en;

    // ------------------------------------------------------------------
    // Write lane selection: narrow data is replicated across the word and
    // the lane mask picks out the addressed half or quarter.
    // ------------------------------------------------------------------
    always_comb begin
        wr_be   = '1;
        wr_word = wr_data;
        case (width_t'(cfg_wr_width))
            W_HALF: begin
                wr_word = {2{wr_data[HALF_W-1:0]}};
                for (int l = 0; l < N_LANE; l++)
                    wr_be[l] = (l / LANES_H) == int'(wr_sel[0]);
            end
            W_QUART: begin
                wr_word = {4{wr_data[QUART_W-1:0]}};
                for (int l = 0; l < N_LANE; l++)
                    wr_be[l] = (l / LANES_Q) == int'(wr_sel);
            end
            default: begin
                wr_be   = '1;
                wr_word = wr_data;
            end
        endcase
    end

    // The sweep owns the write port while busy.
    always_comb begin
        mem_be    = wr_acc ? wr_be : '0;
        mem_addr  = wr_addr;
        mem_wdata = wr_word;
        if (busy) begin
            mem_be    = '1;
            mem_addr  = clr_ptr;
            mem_wdata = '0;
        end
    end

    // NOTE: the array deliberately has no reset branch; only the sweep zeroes it,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        for (int l = 0; l < N_LANE; l++)
            if (mem_be[l]) mem[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end

    // ------------------------------------------------------------------
    // Read path: write-first merge, then slice to the read width
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_acc && (wr_addr == rd_addr)) begin
            for (int l = 0; l < N_LANE; l++)
                if (wr_be[l]) rd_word[l*8 +: 8] = wr_word[l*8 +: 8];
        end
    end

    always_comb begin
        rd_slice = '0;
        case (width_t'(cfg_rd_width))
            W_HALF:  rd_slice[HALF_W-1:0]  = rd_word[int'(rd_sel[0]) * HALF_W +: HALF_W];
            W_QUART: rd_slice[QUART_W-1:0] = rd_word[int'(rd_sel) * QUART_W +: QUART_W];
            default: rd_slice = rd_word;
        endcase
    end

    // Data registers only load on a valid beat, so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            v2 <= 1'b0;
            d2 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= rd_slice;
            v2 <= v1;
            if (v1) d2 <= d1;
        end
    end

    assign rd_data  = cfg_out_reg ? d2 : d1;
    assign rd_valid = cfg_out_reg ? v2 : v1;

endmodule

// File: tb/tb_bram_cfg_dp.sv
// Self-checking bench for bram_cfg_dp: directed scenarios plus randomized traffic
// against a word-array reference model with a latency queue.
module tb_bram_cfg_dp;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int AW_B = 4;
    localparam int DW_B = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, cfg_always_we, cfg_out_reg, clr_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    wr_sel, rd_sel, cfg_wr_width, cfg_rd_width;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_valid, busy;

    logic            b_wr_en, b_rd_en, b_rd_valid, b_busy;
    logic [AW_B-1:0] b_wr_addr, b_rd_addr;
    logic [1:0]      b_wr_sel, b_rd_sel;
    logic [DW_B-1:0] b_wr_data, b_rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } exp_t;

    logic [DW-1:0] model [2**AW];
    exp_t          pipe [$];
    logic [DW-1:0] last_d = '0;
    int            lat = 1;

    bram_cfg_dp #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
        .cfg_always_we(cfg_always_we), .cfg_out_reg(cfg_out_reg),
        .clr_req(clr_req), .busy(busy)
    );

    bram_cfg_dp #(.ADDR_W(AW_B), .DATA_W(DW_B), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_sel(b_rd_sel),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
        .cfg_always_we(cfg_always_we), .cfg_out_reg(cfg_out_reg),
        .clr_req(clr_req), .busy(b_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slice geometry from the width code: 1 = half, 2 = quarter, anything else = full word.
    function automatic int slice_w(input int width);
        if (width == 1) return DW / 2;
        if (width == 2) return DW / 4;
        return DW;
    endfunction

    function automatic int slice_idx(input int width, input int sel);
        if (width == 1) return sel % 2;
        if (width == 2) return sel;
        return 0;
    endfunction

    function automatic logic [DW-1:0] apply_wr(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                                input int width, input int sel);
        logic [DW-1:0] r;
        int w, base;
        r    = old;
        w    = slice_w(width);
        base = slice_idx(width, sel) * w;
        for (int b = 0; b < w; b++) r[base + b] = data[b];
        return r;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [DW-1:0] word, input int width, input int sel);
        logic [DW-1:0] r;
        int w, base;
        r    = '0;
        w    = slice_w(width);
        base = slice_idx(width, sel) * w;
        for (int b = 0; b < w; b++) r[b] = word[base + b];
        return r;
    endfunction

    // One clock of traffic on the 32-bit instance, tracked by the model.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [1:0] ws, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic [1:0] rs, input string tag);
        exp_t e;
        wr_en = we; wr_addr = wa; wr_sel = ws; wr_data = wd;
        rd_en = re; rd_addr = ra; rd_sel = rs;
        if (we || cfg_always_we)
            model[wa] = apply_wr(model[wa], wd, int'(cfg_wr_width), int'(ws));
        if (re) last_d = extract(model[ra], int'(cfg_rd_width), int'(rs));
        e.v = re;
        e.d = last_d;
        pipe.push_back(e);
        tick();
        if (pipe.size() >= lat) begin
            e = pipe.pop_front();
            check({tag, "_valid"}, 64'(rd_valid), 64'(e.v));
            check({tag, "_data"}, 64'(rd_data), 64'(e.d));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 2'd0, '0, 1'b0, '0, 2'd0, "idle");
    endtask

    task automatic set_out_reg(input logic on);
        idle(2);
        cfg_out_reg = on;
        lat = on ? 2 : 1;
        pipe.delete();
    endtask

    task automatic zero_model();
        for (int a = 0; a < 2**AW; a++) model[a] = '0;
    endtask

    int n, n_b;

    initial begin
        rst = 1'b1;
        wr_en = 0; rd_en = 0; cfg_always_we = 0; cfg_out_reg = 0; clr_req = 0;
        wr_addr = '0; rd_addr = '0; wr_sel = '0; rd_sel = '0; wr_data = '0;
        cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;
        b_wr_en = 0; b_rd_en = 0; b_wr_addr = '0; b_rd_addr = '0;
        b_wr_sel = '0; b_rd_sel = '0; b_wr_data = '0;
        zero_model();
        repeat (3) tick();

        check("rst_busy", 64'(busy), 64'd1);
        check("rst_busy_b", 64'(b_busy), 64'd1);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);

        // Requests during the post-reset sweep must be ignored.
        wr_en = 1; wr_addr = 8'd5; wr_data = 32'hFFFF_FFFF; cfg_always_we = 1;
        rd_en = 1; rd_addr = 8'd5;
        rst = 1'b0;
        n = 0; n_b = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (!b_busy && n_b == 0) n_b = n;
            check("sweep_no_rd_valid", 64'(rd_valid), 64'd0);
        end
        wr_en = 0; rd_en = 0; cfg_always_we = 0;
        check("sweep_len", 64'(n), 64'd256);
        check("sweep_len_b", 64'(n_b), 64'd16);

        cyc(0, '0, 0, '0, 1, 8'd0,   0, "rd0_after_sweep");
        cyc(0, '0, 0, '0, 1, 8'd128, 0, "rd128_after_sweep");
        cyc(0, '0, 0, '0, 1, 8'd255, 0, "rd255_after_sweep");
        cyc(0, '0, 0, '0, 1, 8'd5,   0, "rd5_busy_write_dropped");
        check("rd5_const", 64'(rd_data), 64'd0);

        // Full write then quarter overwrite, read back full and half.
        cfg_wr_width = 2'd0;
        cyc(1, 8'h10, 0, 32'hDEAD_BEEF, 0, '0, 0, "w_full");
        cfg_wr_width = 2'd2;
        cyc(1, 8'h10, 2, 32'h0000_0055, 0, '0, 0, "w_quart");
        cfg_rd_width = 2'd0;
        cyc(0, '0, 0, '0, 1, 8'h10, 0, "r_full");
        check("r_full_const", 64'(rd_data), 64'hDE55_BEEF);
        cfg_rd_width = 2'd1;
        cyc(0, '0, 0, '0, 1, 8'h10, 1, "r_half_hi");
        check("r_half_const", 64'(rd_data), 64'h0000_DE55);
        idle(2);
        check("hold_after_read", 64'(rd_data), 64'h0000_DE55);

        // Same-cycle write and read are write-first, with and without output register.
        cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;
        cyc(1, 8'h20, 0, 32'h1234_5678, 1, 8'h20, 0, "wf_lat1");
        check("wf_lat1_const", 64'(rd_data), 64'h1234_5678);
        set_out_reg(1'b1);
        cyc(1, 8'h21, 0, 32'h1234_5678, 1, 8'h21, 0, "wf_lat2");
        check("wf_lat2_n1_valid", 64'(rd_valid), 64'd0);
        idle(1);
        check("wf_lat2_const", 64'(rd_data), 64'h1234_5678);
        set_out_reg(1'b0);

        // Partial write-first merge: quarter write over existing data.
        cfg_wr_width = 2'd2; cfg_rd_width = 2'd0;
        cyc(1, 8'h20, 0, 32'h0000_00AB, 1, 8'h20, 0, "wf_merge");
        check("wf_merge_const", 64'(rd_data), 64'h1234_56AB);

        // cfg_always_we writes without wr_en.
        cfg_wr_width = 2'd0;
        cfg_always_we = 1;
        cyc(0, 8'd3, 0, 32'hA5A5_A5A5, 0, '0, 0, "always_we");
        cfg_always_we = 0;
        cyc(0, '0, 0, '0, 1, 8'd3, 0, "always_we_rd");
        check("always_we_const", 64'(rd_data), 64'hA5A5_A5A5);

        // Randomized traffic over a small address window to provoke collisions.
        for (int ph = 0; ph < 2; ph++) begin
            set_out_reg(ph == 1);
            for (int i = 0; i < 200; i++) begin
                if (i % 8 == 0) begin
                    cfg_wr_width = 2'($urandom_range(0, 3));
                    cfg_rd_width = 2'($urandom_range(0, 3));
                end
                cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), "rand");
            end
        end
        set_out_reg(1'b0);
        cfg_wr_width = 2'd0; cfg_rd_width = 2'd0;

        // clr_req sweep; a second clr_req mid-sweep must not extend it.
        clr_req = 1;
        tick();
        clr_req = 0;
        check("clr_busy", 64'(busy), 64'd1);
        n = 0;
        rd_en = 1;
        while (busy && n < 1000) begin
            clr_req = (n == 50);
            tick();
            n++;
        end
        clr_req = 0; rd_en = 0;
        check("clr_sweep_len", 64'(n), 64'd256);
        check("clr_no_rd_valid", 64'(rd_valid), 64'd0);
        zero_model();
        for (int a = 0; a < 16; a++) cyc(0, '0, 0, '0, 1, AW'(a), 0, "rd_after_clr");

        // Reset in the middle of a sweep restarts it from address 0.
        cyc(1, 8'd7, 0, 32'h7777_7777, 0, '0, 0, "w7");
        cyc(1, 8'd200, 0, 32'hC8C8_C8C8, 0, '0, 0, "w200");
        cyc(0, '0, 0, '0, 1, 8'd7, 0, "r7");
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_rd_data", 64'(rd_data), 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        last_d = '0;
        pipe.delete();
        n = 0; n_b = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (!b_busy && n_b == 0) n_b = n;
        end
        check("midrst_sweep_len", 64'(n), 64'd256);
        check("midrst_sweep_len_b", 64'(n_b), 64'd16);
        zero_model();
        cyc(0, '0, 0, '0, 1, 8'd7,   0, "midrst_rd7");
        cyc(0, '0, 0, '0, 1, 8'd200, 0, "midrst_rd200");
        cyc(0, '0, 0, '0, 1, 8'd0,   0, "midrst_rd0");
        cyc(0, '0, 0, '0, 1, 8'd255, 0, "midrst_rd255");

        // 64-bit instance: quarter write into the top quarter of the last word.
        cfg_wr_width = 2'd2;
        b_wr_en = 1; b_wr_addr = 4'd15; b_wr_sel = 2'd3; b_wr_data = 64'h0000_0000_0000_CAFE;
        tick();
        b_wr_en = 0;
        cfg_rd_width = 2'd0;
        b_rd_en = 1; b_rd_addr = 4'd15; b_rd_sel = 2'd0;
        tick();
        check("b_full_valid", 64'(b_rd_valid), 64'd1);
        check("b_full_data", b_rd_data, 64'hCAFE_0000_0000_0000);
        cfg_rd_width = 2'd1;
        b_rd_sel = 2'd1;
        tick();
        check("b_half_data", b_rd_data, 64'h0000_0000_CAFE_0000);
        b_rd_en = 0;
        tick();
        check("b_valid_drop", 64'(b_rd_valid), 64'd0);
        check("b_hold", b_rd_data, 64'h0000_0000_CAFE_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_cfg_dp.md
BRAM_CFG_DP -- requirements
Module: bram_cfg_dp

Interface
REQ-001 Parameter ADDR_W, default 8, word address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, word width; SHALL be a multiple of 32; N_LANE = DATA_W/8 byte lanes.
REQ-003 Parameter CLEAR_ON_RESET, default 1; 1 = zero the whole array after reset, 0 = skip the clear sweep.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write request, active-high.
REQ-007 wr_addr  input  ADDR_W  write word address.
REQ-008 wr_sel  input  2  write sub-word select: half index in bit 0, quarter index in [1:0].
REQ-009 wr_data  input  DATA_W  write data, right-aligned when narrow.
REQ-010 rd_en  input  1  read request, active-high.
REQ-011 rd_addr  input  ADDR_W  read word address.
REQ-012 rd_sel  input  2  read sub-word select, same encoding as wr_sel.
REQ-013 rd_data  output  DATA_W  read data, right-aligned when narrow.
REQ-014 rd_valid  output  1  rd_data holds the result of an accepted read.
REQ-015 cfg_wr_width  input  2  write port width: 0 full, 1 half, 2 quarter, 3 reserved (treated as full).
REQ-016 cfg_rd_width  input  2  read port width, same encoding as cfg_wr_width.
REQ-017 cfg_always_we  input  1  1 = every cycle is a write, wr_en ignored.
REQ-018 cfg_out_reg  input  1  1 = insert an output register stage.
REQ-019 clr_req  input  1  one-cycle pulse that restarts the clear sweep.
REQ-020 busy  output  1  clear sweep in progress; requests ignored.

Function
REQ-021 Storage SHALL be DEPTH x DATA_W with per-lane write masking.
REQ-022 Write width full SHALL write all lanes with wr_data.
REQ-023 Write width half SHALL write wr_data[DATA_W/2-1:0] into half wr_sel[0] (0 = low half); the other half is unchanged.
REQ-024 Write width quarter SHALL write wr_data[DATA_W/4-1:0] into quarter wr_sel[1:0]; other quarters are unchanged.
REQ-025 Reads SHALL be synchronous: data for a read accepted in cycle N appears in cycle N+1, or N+2 when cfg_out_reg=1.
REQ-026 rd_sel SHALL be captured with the read and travel in the pipeline aligned with its data.
REQ-027 Half and quarter reads SHALL place the selected slice in the low bits of rd_data and drive the upper bits to 0.
REQ-028 rd_valid SHALL follow rd_en (gated by busy) through the same latency as rd_data.
REQ-029 When no read is accepted, rd_data SHALL hold its last value.
REQ-030 Same-cycle read and write to the same address SHALL be write-first: the read returns old data merged with the new lanes.
REQ-031 The state machine SHALL have three states.
- CLEAR: writes 0 to address clr_ptr and increments clr_ptr each cycle; busy=1.
- CLEAR -> READY after address DEPTH-1 is written; clr_ptr wraps to 0.
- READY: normal operation; busy=0.
- READY -> CLEAR on clr_req.
- clr_req while already in CLEAR SHALL be ignored.
REQ-032 While busy=1, wr_en, rd_en and cfg_always_we SHALL have no effect, and no new rd_valid is generated.
REQ-033 Configuration inputs are quasi-static; a change takes effect for requests accepted from the next cycle on.

Reset
REQ-034 On rst the block SHALL immediately clear rd_data, rd_valid, pipeline registers and clr_ptr to 0.
REQ-035 While rst is asserted, busy SHALL equal CLEAR_ON_RESET.
REQ-036 After rst deasserts, the block SHALL enter CLEAR when CLEAR_ON_RESET=1, else READY; the sweep takes exactly DEPTH cycles.
REQ-037 rst asserted mid-sweep SHALL restart the sweep from address 0.
REQ-038 Array contents are not reset asynchronously; only the sweep zeroes them.

Verification
REQ-039 Release reset, count cycles: busy=1 for 256 cycles (defaults); then reading addresses 0, 128 and 255 returns 0 with rd_valid one cycle later.
REQ-040 Full write 0xDEADBEEF @0x10, then quarter write 0x55 with wr_sel=2 @0x10: full read returns 0xDE55BEEF; half read with rd_sel=1 returns 0x0000DE55.
REQ-041 Write 0x12345678 and read @0x20 in the same cycle, location previously 0: rd_data=0x12345678 at N+1; with cfg_out_reg=1 it appears at N+2 with rd_valid aligned.
REQ-042 cfg_always_we=1, wr_en=0, write 0xA5A5A5A5 @3: location written; rd_en during busy: no rd_valid pulse.
REQ-043 Pulse clr_req after data is written, then assert rst at sweep cycle 100: busy stays 1, the sweep restarts from 0, and all locations read 0 after completion.
REQ-044 Instantiate DATA_W=64, ADDR_W=4: quarter write 0xCAFE with wr_sel=3 @15, full read returns 0xCAFE000000000000; the sweep lasts 16 cycles.
